// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
  } sb_slot_t;

  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;

  function automatic logic slot_match(input sb_slot_t s, input logic [2:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : EX/MEM/WB destination scoreboard with decode-source comparators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_issue,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_reg,
  input  logic       i_id_valid,
  input  logic [2:0] i_rs,
  input  logic       i_uses_rs,
  input  logic [2:0] i_rdrq,
  input  logic       i_uses_rdrq,
  output logic       o_hazard,
  output logic       o_all_empty
);

  sb_slot_t r_ex;
  sb_slot_t r_mem;
  sb_slot_t r_wb;
  sb_slot_t w_ex_next;
  logic     w_rs_hit;
  logic     w_rdrq_hit;

  always_comb begin
    w_ex_next = '0;
    if (i_issue) begin
      w_ex_next = '{valid: i_wr_en, rd: i_wr_reg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // WB is excluded: the register file writes in the first half-cycle.
  always_comb begin
    w_rs_hit    = i_uses_rs   && (slot_match(r_ex, i_rs)   || slot_match(r_mem, i_rs));
    w_rdrq_hit  = i_uses_rdrq && (slot_match(r_ex, i_rdrq) || slot_match(r_mem, i_rdrq));
    o_hazard    = i_id_valid && (w_rs_hit || w_rdrq_hit);
    o_all_empty = !r_ex.valid && !r_mem.valid && !r_wb.valid;
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush/halt controller for a 3-stage-after-decode pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [2:0]             id_rs,
  input  logic [2:0]             id_rdrq,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rdrq,
  input  logic                   id_write_en,
  input  logic [2:0]             id_write_reg,
  input  logic                   id_halt,
  input  logic                   ex_branch_taken,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] c_cnt_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_e                 r_state;
  state_e                 w_state_next;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_hazard;
  logic                   w_all_empty;
  logic                   w_issue;
  logic                   w_stall_inc;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_wr_en     (id_write_en),
    .i_wr_reg    (id_write_reg),
    .i_id_valid  (id_valid),
    .i_rs        (id_rs),
    .i_uses_rs   (id_uses_rs),
    .i_rdrq      (id_rdrq),
    .i_uses_rdrq (id_uses_rdrq),
    .o_hazard    (w_hazard),
    .o_all_empty (w_all_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_stall_inc  = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    halted       = 1'b0;

    if (rst) begin
      pc_hold     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          // A taken branch squashes the decode instruction, so it outranks any stall.
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
          end else if (id_valid) begin
            w_issue = 1'b1;
            if (id_halt) begin
              w_state_next = DRAIN;
            end
          end
        end
        DRAIN: begin
          // A redirect while draining means the halt itself was on the wrong path.
          if (ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            w_state_next = RUN;
          end else begin
            pc_hold     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (w_all_empty) begin
              w_state_next = HALTED;
            end
          end
        end
        HALTED: begin
          halted      = 1'b1;
          pc_hold     = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          w_state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl (4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  localparam logic [4:0] CTL_IDLE  = 5'b00000;
  localparam logic [4:0] CTL_RST   = 5'b10110;
  localparam logic [4:0] CTL_STALL = 5'b11010;
  localparam logic [4:0] CTL_FLUSH = 5'b00110;
  localparam logic [4:0] CTL_DRAIN = 5'b10110;
  localparam logic [4:0] CTL_HALT  = 5'b10011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_uses_rs, id_uses_rdrq, id_write_en, id_halt, ex_branch_taken;
  logic [2:0] id_rs, id_rdrq, id_write_reg;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, halted;
  logic [3:0] stall_count;
  logic [4:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, halted}
  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, halted};

  pipeline_ctrl #(.STALL_CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rdrq         (id_rdrq),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rdrq    (id_uses_rdrq),
    .id_write_en     (id_write_en),
    .id_write_reg    (id_write_reg),
    .id_halt         (id_halt),
    .ex_branch_taken (ex_branch_taken),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic urs,
                       input logic [2:0] rdrq, input logic urdrq, input logic we,
                       input logic [2:0] wr, input logic hlt, input logic br);
    id_valid        = v;
    id_rs           = rs;
    id_uses_rs      = urs;
    id_rdrq         = rdrq;
    id_uses_rdrq    = urdrq;
    id_write_en     = we;
    id_write_reg    = wr;
    id_halt         = hlt;
    ex_branch_taken = br;
  endtask

  // Drive decode inputs on the falling edge and check the combinational controls 1ns later.
  task automatic step(input string tag, input logic v, input logic [2:0] rs, input logic urs,
                      input logic [2:0] rdrq, input logic urdrq, input logic we,
                      input logic [2:0] wr, input logic hlt, input logic br,
                      input logic [4:0] exp_ctl);
    @(negedge clk);
    drive(v, rs, urs, rdrq, urdrq, we, wr, hlt, br);
    #1;
    chk(tag, {11'd0, ctl}, {11'd0, exp_ctl});
  endtask

  initial begin
    drive(1, 3'd3, 1, 3'd3, 1, 1, 3'd3, 0, 1);
    @(negedge clk);
    #1;
    chk("rst_ctl", {11'd0, ctl}, {11'd0, CTL_RST});
    chk("rst_cnt", {12'd0, stall_count}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("idle_after_rst", {11'd0, ctl}, {11'd0, CTL_IDLE});

    // Back-to-back RAW on r3: two stall cycles, then issue
    step("a_wr_r3",  1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0, 0, CTL_IDLE);
    step("a_stall1", 1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 0, CTL_STALL);
    chk("a_cnt0", {12'd0, stall_count}, 16'd0);
    step("a_stall2", 1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 0, CTL_STALL);
    chk("a_cnt1", {12'd0, stall_count}, 16'd1);
    step("a_issue",  1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    chk("a_cnt2", {12'd0, stall_count}, 16'd2);

    // RdRq hazard from MEM; unused Rs never stalls
    step("b_wr_r6",     1, 3'd0, 0, 3'd0, 0, 1, 3'd6, 0, 0, CTL_IDLE);
    step("b_unused_rs", 1, 3'd6, 0, 3'd2, 1, 0, 3'd0, 0, 0, CTL_IDLE);
    step("b_rdrq_mem",  1, 3'd0, 0, 3'd6, 1, 0, 3'd0, 0, 0, CTL_STALL);
    step("b_rdrq_wb",   1, 3'd0, 0, 3'd6, 1, 0, 3'd0, 0, 0, CTL_IDLE);
    chk("b_cnt3", {12'd0, stall_count}, 16'd3);

    // Writer of r5 reaches WB: no stall
    step("c_wr_r5", 1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0, 0, CTL_IDLE);
    step("c_gap1",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    step("c_gap2",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    step("c_rd_r5", 1, 3'd5, 1, 3'd5, 1, 0, 3'd0, 0, 0, CTL_IDLE);

    // Branch outranks hazard; r0 is a real register
    step("d_wr_r0",  1, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0, CTL_IDLE);
    step("d_haz_br", 1, 3'd0, 1, 3'd0, 0, 0, 3'd0, 0, 1, CTL_FLUSH);
    step("d_haz_r0", 1, 3'd0, 1, 3'd0, 0, 0, 3'd0, 0, 0, CTL_STALL);
    chk("d_cnt_br_unchanged", {12'd0, stall_count}, 16'd3);
    step("d_issue",  1, 3'd0, 1, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    chk("d_cnt4", {12'd0, stall_count}, 16'd4);

    // Halt with two writers in flight: 3 DRAIN cycles then HALTED
    step("e_wr_r1",  1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 0, 0, CTL_IDLE);
    step("e_wr_r2",  1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0, CTL_IDLE);
    step("e_halt",   1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0, CTL_IDLE);
    step("e_drain1", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_DRAIN);
    step("e_drain2", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_DRAIN);
    step("e_drain3", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_DRAIN);
    step("e_halted", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_HALT);
    step("e_halt_sticky", 1, 3'd1, 1, 3'd2, 1, 1, 3'd1, 0, 1, CTL_HALT);
    chk("e_cnt4", {12'd0, stall_count}, 16'd4);

    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("e_rst_ctl", {11'd0, ctl}, {11'd0, CTL_RST});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("e_unhalted", {11'd0, ctl}, {11'd0, CTL_IDLE});
    chk("e_rst_cnt", {12'd0, stall_count}, 16'd0);

    // Wrong-path halt: branch during DRAIN returns to RUN
    step("f_halt",     1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0, CTL_IDLE);
    step("f_br_drain", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1, CTL_FLUSH);
    step("f_run0",     0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    step("f_run1",     0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);
    step("f_run2",     0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, CTL_IDLE);

    // Dependent chain on r1: issue, stall, stall repeating -> 20 stalls saturate at 4'hF
    for (int i = 0; i < 30; i++) begin
      step("g_chain", 1, 3'd1, 1, 3'd0, 0, 1, 3'd1, 0, 0,
           ((i % 3) == 0) ? CTL_IDLE : CTL_STALL);
    end
    step("g_issue30", 1, 3'd1, 1, 3'd0, 0, 1, 3'd1, 0, 0, CTL_IDLE);
    chk("g_cnt_sat", {12'd0, stall_count}, 16'h000F);
    step("g_stall31", 1, 3'd1, 1, 3'd0, 0, 1, 3'd1, 0, 0, CTL_STALL);
    chk("g_cnt_sat_hold", {12'd0, stall_count}, 16'h000F);

    // Asynchronous reset mid-stall
    #1;
    rst = 1'b1;
    #1;
    chk("g_rst_ctl", {11'd0, ctl}, {11'd0, CTL_RST});
    chk("g_rst_cnt", {12'd0, stall_count}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 3'd1, 1, 3'd1, 1, 0, 3'd0, 0, 0);
    #1;
    chk("g_no_residual", {11'd0, ctl}, {11'd0, CTL_IDLE});
    step("g_no_residual2", 1, 3'd1, 1, 3'd1, 1, 0, 3'd0, 0, 0, CTL_IDLE);
    chk("g_cnt_after", {12'd0, stall_count}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, giving the width of the stall performance counter.
REQ-002 SHALL have clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst input 1: the reset, asynchronous and active-high.
REQ-004 SHALL have id_valid input 1: the decode stage holds a real instruction.
REQ-005 SHALL have id_rs input 3 and id_rdrq input 3: the decode-stage source register numbers (Rs, RdRq).
REQ-006 SHALL have id_uses_rs input 1 and id_uses_rdrq input 1: the sources are actually read.
REQ-007 SHALL have id_write_en input 1 and id_write_reg input 3: the decode-stage destination.
REQ-008 SHALL have id_halt input 1: the decode-stage opcode is 4'b0001.
REQ-009 SHALL have ex_branch_taken input 1: the branch or jump in EX redirects the PC this cycle.
REQ-010 SHALL have pc_hold output 1: the fetch PC must not advance.
REQ-011 SHALL have ifid_hold output 1: the IF/ID register must retain its contents.
REQ-012 SHALL have ifid_flush output 1: the IF/ID register must load a NOP.
REQ-013 SHALL have idex_bubble output 1: the ID/EX register must load a NOP (write_en=0, MemWrite=0, MemRead=0).
REQ-014 SHALL have halted output 1: the core has fully stopped.
REQ-015 SHALL have stall_count output STALL_CNT_W: the count of data-hazard stall cycles.

Function
REQ-016 SHALL keep a 3-slot scoreboard {valid, reg[2:0]} for EX, MEM and WB, shifting EX->MEM->WB every cycle.
REQ-017 SHALL load the EX slot with {id_write_en, id_write_reg} when the decode instruction issues, and with {0, 3'b000} otherwise.
REQ-018 SHALL define an instruction as issuing when id_valid=1, there is no hazard, there is no flush, and the state is RUN.
REQ-019 SHALL raise hazard when id_valid and a used source equals a valid EX or MEM slot register; the WB slot never causes a hazard because the register file writes before it reads.
REQ-020 SHALL treat all 8 registers as real; there is no hardwired-zero exemption.
REQ-021 SHALL, on hazard without flush, assert pc_hold=1, ifid_hold=1 and idex_bubble=1 in the same cycle (combinational), and increment stall_count.
REQ-022 SHALL let ex_branch_taken have priority over hazard: assert ifid_flush=1 and idex_bubble=1, with pc_hold=0 and ifid_hold=0, and leave stall_count unchanged.
REQ-023 SHALL implement the state machine RUN -> DRAIN -> HALTED.
REQ-024 SHALL go from RUN to DRAIN when a halt instruction issues, i.e. id_halt meets the issue conditions.
REQ-025 SHALL, in DRAIN, assert pc_hold=1, ifid_flush=1 and idex_bubble=1 (younger instructions are squashed).
REQ-026 SHALL go from DRAIN to HALTED in the cycle after all three slots are invalid.
REQ-027 SHALL, if ex_branch_taken occurs in DRAIN, treat the halt as wrong-path: return to RUN and apply the REQ-022 flush.
REQ-028 SHALL, in HALTED, assert halted=1, pc_hold=1 and idex_bubble=1; HALTED is left only by reset.
REQ-029 SHALL saturate stall_count at all-ones and never wrap.
REQ-030 SHALL add a latency of 0 cycles for all control outputs (combinational from state, scoreboard and ID inputs) and 1 cycle for scoreboard, state and counter updates.

Reset
REQ-031 SHALL, while rst=1, immediately clear all scoreboard slots, set state=RUN, stall_count=0 and halted=0.
REQ-032 SHALL, while rst=1, drive pc_hold=1, ifid_flush=1, idex_bubble=1 and ifid_hold=0, regardless of the other inputs.
REQ-033 SHALL let a reset asserted mid-stall or mid-DRAIN discard all in-flight hazard state with no residual stall after release.

Structure
REQ-034 SHALL place in the shared package pipe_ctrl_pkg: the state enum (RUN, DRAIN, HALTED), the scoreboard slot struct, and the opcode constants OP_HALT=4'b0001, OP_ST=4'b0111 and OP_LD=4'b1000.
REQ-035 SHALL implement the scoreboard shift register and comparators as the sub-module hazard_scoreboard; the FSM, the priority logic and the counter remain in pipeline_ctrl.

Verification
REQ-036 SHALL cover: issue write r3, next cycle ID reads Rs=r3 -> 2 stall cycles (pc_hold=1, idex_bubble=1), stall_count=2, issue on the third cycle.
REQ-037 SHALL cover: writer of r5 in WB and ID reads r5 -> no stall.
REQ-038 SHALL cover: hazard and ex_branch_taken in the same cycle -> ifid_flush=1, idex_bubble=1, pc_hold=0, stall_count unchanged.
REQ-039 SHALL cover: issue halt with 2 writers in flight -> DRAIN for 3 cycles, then halted=1 with pc_hold=1.
REQ-040 SHALL cover: halt issued, then ex_branch_taken next cycle -> state RUN, halted stays 0.
REQ-041 SHALL cover: stall_count forced near all-ones with STALL_CNT_W=4 and 20 stall cycles -> reads 4'hF; then pulse rst mid-stall -> count 0, all slots empty, no stall after release.
